// File: rtl/logicunit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// logicunit_arbiter_pkg
// Shared encodings for the two-port logic-unit scheduler:
//   op_e    - 2-bit bitwise operation select (AND, OR, NOR, XOR)
//   state_e - 2-bit arbiter FSM state (IDLE, EXEC, RESP)
// -----------------------------------------------------------------------------
package logicunit_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_NOR = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : logicunit_arbiter_pkg

// File: rtl/logicunit_arbiter_logicunit.sv
// -----------------------------------------------------------------------------
// logicunit
// Single-bit bitwise logic cell. The arbiter instantiates one per datapath bit.
// Ports:
//   a_i, b_i - operand bits
//   op_i     - operation select (op_e)
//   y_o      - result bit (combinational)
// -----------------------------------------------------------------------------
module logicunit
    import logicunit_arbiter_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  op_e  op_i,
    output logic y_o
);

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves
        // y_o unassigned, which would otherwise infer a latch.
        y_o = 1'b0;
        unique case (op_i)
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_NOR: y_o = ~(a_i | b_i);
            OP_XOR: y_o = a_i ^ b_i;
            default: y_o = 1'b0;
        endcase
    end

endmodule : logicunit

// File: rtl/logicunit_arbiter.sv
// -----------------------------------------------------------------------------
// logicunit_arbiter
// Round-robin scheduler sharing one WIDTH-bit logic unit between two
// requesters. An accepted op is registered, executed for one cycle, and its
// tagged result is held on the response channel until the consumer takes it.
// Ports:
//   clk, reset_n               - clock, asynchronous active-low reset
//   req{0,1}_valid/_ready      - request handshake (ready combinational)
//   req{0,1}_a/_b/_op          - operands and op select
//   rsp_valid/rsp_ready        - response handshake
//   rsp_id, rsp_data           - issuing requester and result (held after RESP)
//   busy                       - high while in EXEC or RESP
//   op_count                   - completed responses, wraps
// -----------------------------------------------------------------------------
module logicunit_arbiter
    import logicunit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q;
    op_e               op_q;
    logic              id_q;
    logic              last_grant_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              busy_q;
    logic [CNT_W-1:0]  op_count_q;

    logic              any_valid;
    logic              grant_id;
    logic              grant;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic [1:0]        sel_op;
    logic [WIDTH-1:0]  lu_y;

    // Arbitration: on a tie the requester that did not win last time goes;
    // otherwise whichever one is valid.
    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    // reset_n gates the grant so ready stays low while reset is held and
    // rises in the same cycle reset is released.
    assign grant      = reset_n && (state_q == IDLE) && any_valid;
    assign req0_ready = grant && !grant_id;
    assign req1_ready = grant &&  grant_id;

    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;
    assign sel_op = grant_id ? req1_op : req0_op;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lu
        logicunit u_logicunit (
            .a_i  (a_q[i]),
            .b_i  (b_q[i]),
            .op_i (op_q),
            .y_o  (lu_y[i])
        );
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_AND;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        op_q         <= op_e'(sel_op);
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= lu_y;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        op_count_q  <= op_count_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule : logicunit_arbiter

// File: tb/tb_logicunit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logicunit_arbiter
// Directed bench for logicunit_arbiter. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled 1 more unit later, clear of the edge.
// The counter width is narrowed to 4 bits so the wrap is reachable quickly.
// -----------------------------------------------------------------------------
module tb_logicunit_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]       req0_op, req1_op;
    logic             rsp_valid, rsp_ready, rsp_id, busy;
    logic [WIDTH-1:0] rsp_data;
    logic [CNT_W-1:0] op_count;

    int n_pass  = 0;
    int n_total = 0;

    logicunit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; leaves time at posedge+1 for driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on a single requester and check latency, result and tag.
    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        check("op_ready", {62'd0, req1_ready, req0_ready}, id ? 64'd2 : 64'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("op_exec", {62'd0, busy, rsp_valid}, 64'd2);
        tick();
        #1;
        check("op_rsp", {30'd0, rsp_valid, rsp_id, rsp_data}, {30'd0, 1'b1, id, exp});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int   seen;
        int   cyc;
        int   last_cyc;
        logic rose;

        reset_n    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = 2'd0;
        req1_a = '0; req1_b = '0; req1_op = 2'd0;
        rsp_ready  = 1'b0;

        // Reset held with both requesters valid: every output low.
        repeat (3) tick();
        #1;
        check("reset_outputs",
              {req0_ready, req1_ready, rsp_valid, rsp_id, busy, op_count, rsp_data},
              64'd0);
        reset_n = 1'b1;
        #1;
        check("release_ready", {62'd0, req0_ready, req1_ready}, 64'd2);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("idle_no_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        tick();

        // Single XOR on requester 0.
        run_op(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd3, 32'h0FF0_0FF0);
        #1;
        check("count_after_single", {60'd0, op_count}, 64'd1);

        // All four ops on requester 1.
        run_op(1'b1, 32'hAAAA_5555, 32'h0F0F_0F0F, 2'd0, 32'h0A0A_0505);
        run_op(1'b1, 32'hAAAA_5555, 32'h0F0F_0F0F, 2'd1, 32'hAFAF_5F5F);
        run_op(1'b1, 32'hAAAA_5555, 32'h0F0F_0F0F, 2'd2, 32'h5050_A0A0);
        run_op(1'b1, 32'hAAAA_5555, 32'h0F0F_0F0F, 2'd3, 32'hA5A5_5A5A);
        #1;
        check("count_after_ops", {60'd0, op_count}, 64'd5);

        // Contention: last grant went to 1, so 0 wins first, then alternate.
        req0_a = 32'hFFFF_0000; req0_b = 32'h1234_5678; req0_op = 2'd1;
        req1_a = 32'hFFFF_0000; req1_b = 32'h1234_5678; req1_op = 2'd3;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        check("tie_first_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
        seen = 0;
        last_cyc = 0;
        for (cyc = 1; cyc <= 30 && seen < 4; cyc++) begin
            tick();
            #1;
            if (rsp_valid) begin
                check("rr_id", {63'd0, rsp_id}, {63'd0, seen[0]});
                check("rr_data", {32'd0, rsp_data},
                      seen[0] ? 64'h0000_0000_EDCB_5678 : 64'h0000_0000_FFFF_5678);
                if (seen > 0) check("rr_interval", 64'(cyc - last_cyc), 64'd3);
                last_cyc = cyc;
                seen++;
                if (seen == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        check("rr_responses", 64'(seen), 64'd4);
        tick();
        rsp_ready = 1'b0;
        #1;
        check("count_after_rr", {60'd0, op_count}, 64'd9);

        // Backpressure: response held for 10 cycles with both requesters pushing.
        req0_valid = 1'b1; req0_a = 32'h1357_9BDF; req0_b = 32'hFFFF_0000; req0_op = 2'd0;
        tick();
        req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_stable",
                  {24'd0, rsp_valid, rsp_id, req0_ready, req1_ready, op_count, rsp_data},
                  {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 32'h1357_0000});
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("bp_release", {59'd0, rsp_valid, op_count}, 64'd10);
        check("data_held", {32'd0, rsp_data}, 64'h0000_0000_1357_0000);

        // Mid-op reset during EXEC: op discarded, everything cleared.
        req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0; req0_op = 2'd1;
        tick();
        #1;
        check("mid_exec_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        req0_valid = 1'b0;
        #1;
        check("mid_reset_clear", {29'd0, rsp_valid, busy, op_count, rsp_data}, 64'd0);
        reset_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (rsp_valid) rose = 1'b1;
        end
        check("mid_reset_no_rsp", {63'd0, rose}, 64'd0);
        check("mid_reset_count", {60'd0, op_count}, 64'd0);

        // Counter wrap: 15 completions reach the maximum, one more returns to 0.
        for (int i = 0; i < 15; i++)
            run_op(i[0], 32'h0000_00FF, 32'h0000_0F0F, 2'd1, 32'h0000_0FFF);
        #1;
        check("count_max", {60'd0, op_count}, 64'd15);
        run_op(1'b0, 32'h0000_00FF, 32'h0000_0F0F, 2'd0, 32'h0000_000F);
        #1;
        check("count_wrap", {60'd0, op_count}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_logicunit_arbiter

// File: doc/logicunit_arbiter.md
# logicunit_arbiter

Two-port scheduler that shares one WIDTH-bit logic unit (AND/OR/NOR/XOR) between two requesters. Each requester presents operands and a 2-bit op over a valid/ready handshake. The arbiter grants round-robin, registers operands, runs the logic unit for one cycle, and holds the tagged result on a response channel until it is accepted. It sits between the lab's control logic and the shared bitwise datapath.

## Interface
- WIDTH, 32, operand/result width in bits
- CNT_W, 16, width of completed-operation counter
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid, req1_valid  in  1  requester has an op pending
- req0_ready, req1_ready  out  1  op accepted this cycle (handshake = valid & ready)
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands
- req0_op, req1_op  in  2  op: 0 AND, 1 OR, 2 NOR, 3 XOR
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that issued the op
- rsp_data  out  WIDTH  result
- busy  out  1  high in EXEC or RESP
- op_count  out  CNT_W  completed responses, wraps

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any req valid, assert ready to exactly one requester (combinational from valid and last_grant); on handshake latch a, b, op, id; go EXEC. No valid -> stay IDLE, both ready low.
- Arbitration: both valid -> grant requester != last_grant; one valid -> grant it. last_grant updates on every grant. Reset value of last_grant = 1, so requester 0 wins the first tie.
- EXEC: logic unit computes on latched operands; result captured into rsp_data, id into rsp_id; go RESP.
- RESP: rsp_valid = 1, rsp_data/rsp_id stable; both req ready low. On rsp_valid & rsp_ready: op_count += 1 (wraps 2^CNT_W-1 -> 0), go IDLE.
- Requesters may change/drop valid while not granted; no request is latched without handshake.
- rsp_data/rsp_id hold last value after leaving RESP (not cleared).
- Reset values: req*_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, op_count 0.
- reset_n asserted mid-op: all state cleared immediately, in-flight op discarded, no response emitted.

## Timing
- Accept at cycle N edge -> EXEC during N+1 -> rsp_valid high from N+2.
- Latency 2 cycles accept-to-response; rsp_valid held indefinitely under backpressure.
- Response handshake at cycle M -> IDLE at M+1; next accept earliest M+1. Peak throughput 1 op / 3 cycles.
- ready is combinational from valid in IDLE; never depends on rsp_ready.
- All outputs except req*_ready are registered.

## Structure
- Shared package/include: op encodings (OP_AND=0, OP_OR=1, OP_NOR=2, OP_XOR=3) and state encodings (IDLE, EXEC, RESP, 2-bit).
- Sub-module: existing `logicunit`, instantiated WIDTH times via generate (one per bit), control from latched op.
- Arbiter FSM, operand/result registers and counter in the top module.

## Test plan
- Reset: hold reset_n=0 with both valid -> all outputs 0; release -> req0_ready=1, req1_ready=0 same cycle.
- Single op: req0 a=0xF0F0F0F0, b=0xFF00FF00, op=3 -> rsp_valid 2 cycles later, rsp_data=0x0FF00FF0, rsp_id=0, op_count=1 after rsp_ready.
- All ops on a=0xAAAA5555, b=0x0F0F0F0F: AND 0x0A0A0505, OR 0xAFAF5F5F, NOR 0x5050A0A0, XOR 0xA5A55A5A.
- Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each response every 3 cycles.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/data/id stable, both ready low, op_count unchanged; then rsp_ready=1 -> single count increment.
- Mid-op reset: pulse reset_n low during EXEC -> rsp_valid never rises for that op; op_count 0; op_count preset to 0xFFFF then one completion -> 0x0000.
